// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: two-flop synchroniser, bounce filter,
// and registered press/release/long-press pulses for every channel.

module btn_debounce_lane #(
    parameter int NB_CNT          = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold,
    output logic o_press_next
);

    localparam logic [NB_CNT-1:0] DB_LAST   = NB_CNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_CNT-1:0] HOLD_LAST = NB_CNT'(HOLD_CYCLES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [NB_CNT-1:0] r_cnt;
    logic              r_press;
    logic              r_release;
    logic [NB_CNT-1:0] r_hcnt;
    logic              r_fired;
    logic              r_hold;

    logic              w_diff;
    logic              w_accept;

    assign w_diff       = (r_sync2 != r_level);
    assign w_accept     = w_diff && (r_cnt == DB_LAST);
    assign o_press_next = w_accept && r_sync2;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample that agrees with the stable level restarts the count.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept && r_sync2;
            r_release <= w_accept && !r_sync2;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // The press edge sees the old level (0), so it clears the hold state too.
    // A release accepted on the terminal hold cycle wins over the hold pulse.
    always_ff @(posedge clock) begin
        if (i_reset || !r_level || w_accept) begin
            r_hcnt  <= '0;
            r_fired <= 1'b0;
            r_hold  <= 1'b0;
        end else if (!r_fired && (r_hcnt == HOLD_LAST)) begin
            r_fired <= 1'b1;
            r_hold  <= 1'b1;
        end else begin
            r_hold <= 1'b0;
            if (!r_fired) begin
                r_hcnt <= r_hcnt + CNT_ONE;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

module btn_debounce #(
    parameter int NB_BTN          = 4,
    parameter int NB_CNT          = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_level,
    output logic [NB_BTN-1:0] o_press,
    output logic [NB_BTN-1:0] o_release,
    output logic [NB_BTN-1:0] o_hold,
    output logic              o_press_any
);

    logic [NB_BTN-1:0] w_press_next;
    logic              r_press_any;

    for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_lane
        btn_debounce_lane #(
            .NB_CNT          (NB_CNT),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_lane (
            .clock        (clock),
            .i_reset      (i_reset),
            .i_btn        (i_btn[gi]),
            .o_level      (o_level[gi]),
            .o_press      (o_press[gi]),
            .o_release    (o_release[gi]),
            .o_hold       (o_hold[gi]),
            .o_press_next (w_press_next[gi])
        );
    end

    // Registered from the lanes' next-press terms so it lines up with o_press.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_press_any <= 1'b0;
        end else begin
            r_press_any <= |w_press_next;
        end
    end

    assign o_press_any = r_press_any;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a window-based reference model checked
// every cycle, plus literal latency expectations from the test plan.

module tb_btn_debounce;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int HC = 10;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1;
    logic [NB-1:0] i_btn = '0;
    logic [NB-1:0] o_level, o_press, o_release, o_hold;
    logic          o_press_any;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .NB_BTN          (NB),
        .NB_CNT          (20),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_btn       (i_btn),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_hold      (o_hold),
        .o_press_any (o_press_any)
    );

    always #5 clock = ~clock;

    // Reference model: raw samples reach the filter two edges late; a new level
    // is taken once the last DB filter samples since the previous change all
    // disagree with the current level. Hold fires HC edges after the press edge.
    logic [NB-1:0] raw_q[$];
    bit            win[NB][$];
    logic [NB-1:0] m_lvl = '0;
    logic [NB-1:0] e_level = '0, e_press = '0, e_release = '0, e_hold = '0;
    logic          e_any = 1'b0;
    int            cyc_no = 0;
    int            press_at[NB];

    task automatic model_step();
        logic [NB-1:0] used;
        bit acc;
        cyc_no++;
        e_press   = '0;
        e_release = '0;
        e_hold    = '0;
        if (i_reset) begin
            raw_q.delete();
            raw_q.push_back('0);
            raw_q.push_back('0);
            for (int ch = 0; ch < NB; ch++) win[ch].delete();
            m_lvl = '0;
        end else begin
            raw_q.push_back(i_btn);
            used = raw_q.pop_front();
            for (int ch = 0; ch < NB; ch++) begin
                win[ch].push_back(used[ch]);
                if (win[ch].size() > DB) void'(win[ch].pop_front());
                acc = (win[ch].size() == DB);
                for (int i = 0; i < win[ch].size(); i++)
                    if (win[ch][i] == m_lvl[ch]) acc = 0;
                if (m_lvl[ch] && !acc && (cyc_no - press_at[ch] == HC)) e_hold[ch] = 1'b1;
                if (acc) begin
                    m_lvl[ch] = ~m_lvl[ch];
                    win[ch].delete();
                    if (m_lvl[ch]) begin
                        e_press[ch] = 1'b1;
                        press_at[ch] = cyc_no;
                    end else begin
                        e_release[ch] = 1'b1;
                    end
                end
            end
        end
        e_level = m_lvl;
        e_any   = |e_press;
    endtask

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc_no, act, exp);
        end
    endtask

    // One clock: model at the edge, compare at the following falling edge.
    task automatic cyc();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("level",   o_level,   e_level);
        chk("press",   o_press,   e_press);
        chk("release", o_release, e_release);
        chk("hold",    o_hold,    e_hold);
        chk("any",     {3'b000, o_press_any}, {3'b000, e_any});
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int cnt_p, cnt_r, cnt_h;

    initial begin
        for (int ch = 0; ch < NB; ch++) press_at[ch] = -1000;

        // Reset
        i_reset = 1'b1;
        cycn(3);
        chk("lit_reset_level", o_level, 4'b0000);
        chk("lit_reset_pulses", o_press | o_release | o_hold, 4'b0000);
        @(negedge clock);
        i_reset = 1'b0;
        cycn(3);

        // Clean press on ch0: press after edge k+5, i.e. the 6th edge
        i_btn[0] = 1'b1;
        cycn(5);
        chk("lit_clean_pre", o_level, 4'b0000);
        cyc();
        chk("lit_clean_press", o_press, 4'b0001);
        chk("lit_clean_any", {3'b000, o_press_any}, 4'b0001);
        chk("lit_clean_level", o_level, 4'b0001);
        cyc();
        chk("lit_clean_once", o_press, 4'b0000);
        i_btn[0] = 1'b0;
        cycn(5);
        chk("lit_clean_rel_pre", o_release, 4'b0000);
        cyc();
        chk("lit_clean_release", o_release, 4'b0001);
        cycn(4);

        // Bounce on ch1, then a stable press
        cnt_p = 0; cnt_r = 0;
        i_btn[1] = 1'b1; cyc();
        i_btn[1] = 1'b0; cyc();
        i_btn[1] = 1'b1; cyc();
        i_btn[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            cnt_p += int'(o_press[1]);
            cnt_r += int'(o_release[1]);
        end
        chk("lit_bounce_quiet", {2'b00, cnt_p[0] | cnt_r[0], o_level[1]}, 4'b0000);
        i_btn[1] = 1'b1;
        cnt_p = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            cnt_p += int'(o_press[1]);
        end
        chk("lit_bounce_single", 4'(cnt_p), 4'd1);
        i_btn[1] = 1'b0;
        cycn(8);

        // Long press on ch2: press at 6th edge, hold 10 edges later, once only
        i_btn[2] = 1'b1;
        cycn(6);
        chk("lit_long_press", o_press, 4'b0100);
        cycn(9);
        chk("lit_long_hold_pre", o_hold, 4'b0000);
        cyc();
        chk("lit_long_hold", o_hold, 4'b0100);
        cnt_h = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            cnt_h += int'(o_hold[2]);
        end
        chk("lit_long_no_rehold", 4'(cnt_h), 4'd0);
        i_btn[2] = 1'b0;
        cycn(6);
        chk("lit_long_release", o_release, 4'b0100);
        cycn(4);

        // Short press on ch3: released before hold can fire
        i_btn[3] = 1'b1;
        cycn(6);
        chk("lit_short_press", o_press, 4'b1000);
        cycn(3);
        i_btn[3] = 1'b0;
        cnt_h = 0; cnt_r = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            cnt_h += int'(o_hold[3]);
            cnt_r += int'(o_release[3]);
        end
        chk("lit_short_nohold", 4'(cnt_h), 4'd0);
        chk("lit_short_release", 4'(cnt_r), 4'd1);

        // Simultaneous press on ch0 and ch1
        i_btn = 4'b0011;
        cycn(6);
        chk("lit_sim_press", o_press, 4'b0011);
        chk("lit_sim_any", {3'b000, o_press_any}, 4'b0001);
        cyc();
        chk("lit_sim_any_once", {3'b000, o_press_any}, 4'b0000);
        i_btn = 4'b0000;
        cycn(8);

        // Reset two cycles into a count, button held through it
        i_btn[0] = 1'b1;
        cycn(3);
        i_reset = 1'b1;
        cycn(2);
        chk("lit_rst_outs", o_level | o_press | o_release | o_hold, 4'b0000);
        i_reset = 1'b0;
        cycn(5);
        chk("lit_rst_pre", o_press, 4'b0000);
        cyc();
        chk("lit_rst_press", o_press, 4'b0001);
        i_btn[0] = 1'b0;
        cycn(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
